// File: rtl/interrupt_ack_sequencer.sv
// 8259-style two-pulse INTA acknowledge sequencer: raises INT, sets ISR on INTA1, drives {ICW2,idx} on INTA2.
// Optional automatic EOI strobe on INTA2 release is compiled in with macro AEOI_EN.
module interrupt_ack_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       INT_request,
    input  logic [2:0] serviced_interrupt_index,
    input  logic [4:0] ICW2_vector,
    input  logic       INTA_n,
    output logic       INT,
    output logic       INT_requestAck,
    output logic       freezing,
    output logic       ISR_set,
    output logic [2:0] ISR_set_index,
    output logic [7:0] data_out,
    output logic       data_out_en,
    output logic       EOI_strobe,
    output logic [2:0] EOI_index
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ACK1 = 3'd1,
        WAIT_ACK2 = 3'd2,
        DRIVE_VEC = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_t     state_q, state_d;
    logic       inta_prev_q;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hold_q, hold_d;
    logic       int_q, int_d;
    logic       ack_q, ack_d;
    logic       freeze_q, freeze_d;
    logic       isr_set_q, isr_set_d;
    logic [2:0] isr_idx_q, isr_idx_d;
    logic       inta_fall;

    assign inta_fall = inta_prev_q & ~INTA_n;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        int_d     = int_q;
        ack_d     = ack_q;
        freeze_d  = freeze_q;
        isr_set_d = 1'b0;
        isr_idx_d = isr_idx_q;
        case (state_q)
            IDLE: begin
                if (INT_request) begin
                    int_d   = 1'b1;
                    state_d = WAIT_ACK1;
                end
            end
            WAIT_ACK1: begin
                // INTA1 wins over a request that drops in the same cycle
                if (inta_fall) begin
                    idx_d     = serviced_interrupt_index;
                    isr_set_d = 1'b1;
                    isr_idx_d = serviced_interrupt_index;
                    freeze_d  = 1'b1;
                    int_d     = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = WAIT_ACK2;
                end else if (!INT_request) begin
                    int_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT_ACK2: begin
                cnt_d = cnt_q + 8'd1;
                if (inta_fall) begin
                    state_d = DRIVE_VEC;
                end else if (cnt_d == TIMEOUT_LIM) begin
                    freeze_d = 1'b0;
                    hold_d   = 1'b0;
                    state_d  = HOLDOFF;
                end
            end
            DRIVE_VEC: begin
                if (INTA_n) begin
                    freeze_d = 1'b0;
                    ack_d    = ~ack_q;
                    hold_d   = 1'b0;
                    state_d  = HOLDOFF;
                end
            end
            HOLDOFF: begin
                hold_d = 1'b1;
                if (hold_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            inta_prev_q <= 1'b1;
            idx_q       <= 3'd0;
            cnt_q       <= 8'd0;
            hold_q      <= 1'b0;
            int_q       <= 1'b0;
            ack_q       <= 1'b0;
            freeze_q    <= 1'b0;
            isr_set_q   <= 1'b0;
            isr_idx_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= INTA_n;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            int_q       <= int_d;
            ack_q       <= ack_d;
            freeze_q    <= freeze_d;
            isr_set_q   <= isr_set_d;
            isr_idx_q   <= isr_idx_d;
        end
    end

`ifdef AEOI_EN
    logic       eoi_q, eoi_d;
    logic [2:0] eoi_idx_q, eoi_idx_d;

    always_comb begin
        eoi_d     = 1'b0;
        eoi_idx_d = eoi_idx_q;
        if (state_q == DRIVE_VEC && INTA_n) begin
            eoi_d     = 1'b1;
            eoi_idx_d = idx_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eoi_q     <= 1'b0;
            eoi_idx_q <= 3'd0;
        end else begin
            eoi_q     <= eoi_d;
            eoi_idx_q <= eoi_idx_d;
        end
    end

    assign EOI_strobe = eoi_q;
    assign EOI_index  = eoi_idx_q;
`else
    assign EOI_strobe = 1'b0;
    assign EOI_index  = 3'd0;
`endif

    // Vector is driven combinationally so the bus releases the moment INTA_n rises or reset hits
    assign data_out_en    = (state_q == DRIVE_VEC) && !INTA_n;
    assign data_out       = data_out_en ? {ICW2_vector, idx_q} : 8'h00;
    assign INT            = int_q;
    assign INT_requestAck = ack_q;
    assign freezing       = freeze_q;
    assign ISR_set        = isr_set_q;
    assign ISR_set_index  = isr_idx_q;

endmodule
